// File: rtl/main_aes128.sv
// Iterative AES-128 encryptor: one round per clock with on-the-fly key expansion.
// Result is held with ready=1 until the next start or reset.

module aes_sbox (
   input  logic [7:0] a,
   output logic [7:0] y
);

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   assign y = SBOX[a];

endmodule

module main_aes128 (
   input  logic         clock,
   input  logic         reset,
   input  logic [127:0] key,
   input  logic [127:0] plaintext,
   input  logic         start,
   output logic [127:0] ciphertext,
   output logic         ready
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} fsm_t;

   fsm_t         fsm_q, fsm_d;
   logic [127:0] state_q, rkey_q, ct_q;
   logic [3:0]   round_q;
   logic         last;
   logic [7:0]   rcon;
   logic [7:0]   sb_out [16];
   logic [7:0]   sr [16];
   logic [7:0]   mc [16];
   logic [31:0]  rot, sub;
   logic [127:0] next_key, round_out;

   function automatic logic [7:0] xt(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
   endfunction

   assign last = (round_q == 4'd10);

   always_comb begin
      unique case (round_q)
         4'd1:    rcon = 8'h01;
         4'd2:    rcon = 8'h02;
         4'd3:    rcon = 8'h04;
         4'd4:    rcon = 8'h08;
         4'd5:    rcon = 8'h10;
         4'd6:    rcon = 8'h20;
         4'd7:    rcon = 8'h40;
         4'd8:    rcon = 8'h80;
         4'd9:    rcon = 8'h1b;
         4'd10:   rcon = 8'h36;
         default: rcon = 8'h00;
      endcase
   end

   // Key schedule: SubWord(RotWord(w3)) ^ Rcon, then the xor chain
   assign rot = {rkey_q[23:0], rkey_q[31:24]};

   for (genvar j = 0; j < 4; j++) begin : g_ksb
      aes_sbox u_ksb (.a(rot[31-8*j -: 8]), .y(sub[31-8*j -: 8]));
   end

   always_comb begin
      next_key[127:96] = rkey_q[127:96] ^ sub ^ {rcon, 24'h0};
      next_key[95:64]  = rkey_q[95:64] ^ next_key[127:96];
      next_key[63:32]  = rkey_q[63:32] ^ next_key[95:64];
      next_key[31:0]   = rkey_q[31:0] ^ next_key[63:32];
   end

   for (genvar i = 0; i < 16; i++) begin : g_ssb
      aes_sbox u_ssb (.a(state_q[127-8*i -: 8]), .y(sb_out[i]));
   end

   // Byte 4c+r is row r of column c; ShiftRows rotates row r left by r
   for (genvar c = 0; c < 4; c++) begin : g_col
      for (genvar r = 0; r < 4; r++) begin : g_row
         assign sr[4*c+r] = sb_out[4*((c+r)%4)+r];
      end
      assign mc[4*c+0] = last ? sr[4*c+0] :
         xt(sr[4*c+0]) ^ xt(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
      assign mc[4*c+1] = last ? sr[4*c+1] :
         sr[4*c+0] ^ xt(sr[4*c+1]) ^ xt(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
      assign mc[4*c+2] = last ? sr[4*c+2] :
         sr[4*c+0] ^ sr[4*c+1] ^ xt(sr[4*c+2]) ^ xt(sr[4*c+3]) ^ sr[4*c+3];
      assign mc[4*c+3] = last ? sr[4*c+3] :
         xt(sr[4*c+0]) ^ sr[4*c+0] ^ sr[4*c+1] ^ sr[4*c+2] ^ xt(sr[4*c+3]);
   end

   for (genvar i = 0; i < 16; i++) begin : g_ark
      assign round_out[127-8*i -: 8] = mc[i] ^ next_key[127-8*i -: 8];
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) fsm_q <= IDLE;
      else        fsm_q <= fsm_d;
   end

   always_comb begin
      fsm_d = fsm_q;
      ready = 1'b0;
      unique case (fsm_q)
         IDLE:    if (start) fsm_d = BUSY;
         BUSY:    if (start) fsm_d = BUSY;
                  else if (last) fsm_d = DONE;
         DONE: begin
            ready = 1'b1;
            if (start) fsm_d = BUSY;
         end
         default: fsm_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= '0;
         rkey_q  <= '0;
         ct_q    <= '0;
         round_q <= '0;
      end else if (start) begin
         state_q <= plaintext ^ key;
         rkey_q  <= key;
         round_q <= 4'd1;
      end else if (fsm_q == BUSY) begin
         state_q <= round_out;
         rkey_q  <= next_key;
         if (last) begin
            ct_q    <= round_out;
            round_q <= '0;
         end else begin
            round_q <= round_q + 4'd1;
         end
      end
   end

   assign ciphertext = ct_q;

endmodule

// File: tb/tb_main_aes128.sv
// Directed bench for main_aes128: FIPS-197 vectors, restart, abort,
// asynchronous reset and input-stability corner cases.

module tb_main_aes128;

   logic         clock = 1'b0;
   logic         reset;
   logic [127:0] key;
   logic [127:0] plaintext;
   logic         start;
   logic [127:0] ciphertext;
   logic         ready;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [127:0] k;
      logic [127:0] p;
      logic [127:0] c;
   } vec_t;

   vec_t vecs [3];

   main_aes128 dut (
      .clock(clock),
      .reset(reset),
      .key(key),
      .plaintext(plaintext),
      .start(start),
      .ciphertext(ciphertext),
      .ready(ready)
   );

   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string name, input logic [127:0] act,
                        input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic start_op(input logic [127:0] k, input logic [127:0] p);
      key       = k;
      plaintext = p;
      start     = 1'b1;
      step();
      start     = 1'b0;
   endtask

   // After a start edge: 9 more edges not ready, 10th edge ready with c
   task automatic finish_op(input string name, input logic [127:0] c);
      repeat (9) step();
      check({name, "_ready_early"}, {127'b0, ready}, 128'd0);
      step();
      check({name, "_ready"}, {127'b0, ready}, 128'd1);
      check({name, "_ct"}, ciphertext, c);
   endtask

   initial begin
      vecs[0] = '{128'h2b7e151628aed2a6abf7158809cf4f3c,
                  128'h3243f6a8885a308d313198a2e0370734,
                  128'h3925841d02dc09fbdc118597196a0b32};
      vecs[1] = '{128'h0, 128'h0,
                  128'h66e94bd4ef8a2c3b884cfa59ca342b2e};
      vecs[2] = '{128'h000102030405060708090a0b0c0d0e0f,
                  128'h00112233445566778899aabbccddeeff,
                  128'h69c4e0d86a7b0430d8cdb78070b4c55a};

      reset     = 1'b0;
      start     = 1'b1;
      key       = vecs[2].k;
      plaintext = vecs[2].p;
      repeat (3) step();
      check("rst_ready", {127'b0, ready}, 128'd0);
      check("rst_ct", ciphertext, 128'd0);
      start = 1'b0;
      #3 reset = 1'b1;
      repeat (12) step();
      check("idle_ready", {127'b0, ready}, 128'd0);
      check("idle_ct", ciphertext, 128'd0);

      for (int i = 0; i < 3; i++) begin
         start_op(vecs[i].k, vecs[i].p);
         check($sformatf("v%0d_ready_drop", i), {127'b0, ready}, 128'd0);
         finish_op($sformatf("v%0d", i), vecs[i].c);
      end

      for (int i = 0; i < 5; i++) begin
         step();
         check($sformatf("hold%0d", i), {ready, ciphertext},
               {1'b1, vecs[2].c});
      end

      // Abort at round 5 with a restart carrying different inputs
      start_op(vecs[0].k, vecs[0].p);
      repeat (4) step();
      check("abort_busy", {127'b0, ready}, 128'd0);
      start_op(vecs[2].k, vecs[2].p);
      finish_op("abort", vecs[2].c);

      // Asynchronous reset in round 6
      start_op(vecs[1].k, vecs[1].p);
      repeat (5) step();
      #2 reset = 1'b0;
      #1;
      check("areset_ready", {127'b0, ready}, 128'd0);
      check("areset_ct", ciphertext, 128'd0);
      #2 reset = 1'b1;
      repeat (12) step();
      check("post_rst_ready", {127'b0, ready}, 128'd0);
      check("post_rst_ct", ciphertext, 128'd0);

      // Start held high: reload every edge, never ready
      key       = vecs[0].k;
      plaintext = vecs[0].p;
      start     = 1'b1;
      for (int i = 0; i < 12; i++) begin
         step();
         check($sformatf("held%0d_ready", i), {127'b0, ready}, 128'd0);
      end
      start = 1'b0;
      finish_op("held_release", vecs[0].c);

      // Inputs changed after the start edge must not matter
      start_op(vecs[2].k, vecs[2].p);
      key       = 128'hdeadbeef_01234567_89abcdef_cafef00d;
      plaintext = 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;
      finish_op("stable_in", vecs[2].c);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
